// File: rtl/ladybird_debug_injector.sv
// Debug instruction injector: expands abstract register/memory commands into
// short RV32I sequences, feeds them to the core one at a time, returns results.
module ladybird_debug_injector #(
  parameter logic [4:0] SCRATCH0 = 5'd5,
  parameter logic [4:0] SCRATCH1 = 5'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_regno,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  input  logic        inst_done,
  input  logic        inst_fault,
  input  logic [31:0] inst_result,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {OP_RREAD, OP_RWRITE, OP_MREAD, OP_MWRITE} op_t;

  function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] f_lb(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] f_sb(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
  endfunction

  // Upper part rounded so that the sign-extended 12-bit low part adds back exactly.
  function automatic logic [19:0] f_hi(input logic [31:0] v);
    logic [31:0] s;
    s = v + 32'h0000_0800;
    return s[31:12];
  endfunction

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [4:0]  regno_q, regno_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] seq_word;
  logic [1:0]  last_step;
  logic        is_read;

  always_comb begin
    seq_word = 32'h0;
    case (op_q)
      OP_RREAD:  seq_word = f_addi(5'd0, regno_q, 12'h000);
      OP_RWRITE: seq_word = (step_q == 2'd0) ? f_lui(regno_q, f_hi(data_q))
                                             : f_addi(regno_q, regno_q, data_q[11:0]);
      OP_MREAD: begin
        case (step_q)
          2'd0:    seq_word = f_lui(SCRATCH0, f_hi(addr_q));
          2'd1:    seq_word = f_lb(SCRATCH0, SCRATCH0, addr_q[11:0]);
          default: seq_word = f_addi(5'd0, SCRATCH0, 12'h000);
        endcase
      end
      OP_MWRITE: begin
        case (step_q)
          2'd0:    seq_word = f_lui(SCRATCH0, f_hi(addr_q));
          2'd1:    seq_word = f_addi(SCRATCH1, 5'd0, {4'b0000, data_q[7:0]});
          default: seq_word = f_sb(SCRATCH1, SCRATCH0, addr_q[11:0]);
        endcase
      end
      default: seq_word = 32'h0;
    endcase
  end

  assign last_step = (op_q == OP_RREAD) ? 2'd0 : (op_q == OP_RWRITE) ? 2'd1 : 2'd2;
  assign is_read   = (op_q == OP_RREAD) || (op_q == OP_MREAD);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    regno_d = regno_q;
    addr_d  = addr_q;
    data_d  = data_q;
    step_d  = step_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          regno_d = cmd_regno;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          step_d  = 2'd0;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (inst_ready) state_d = S_WAIT;
      // A fault aborts the remaining steps; the response still goes out.
      S_WAIT: begin
        if (inst_done) begin
          if (inst_fault) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (step_q == last_step) begin
            if (is_read) rdata_d = inst_result;
            state_d = S_RESP;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_RREAD;
      regno_q <= 5'd0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      step_q  <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      regno_q <= regno_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      step_q  <= step_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign inst_valid = (state_q == S_ISSUE);
  assign inst_data  = (state_q == S_ISSUE) ? seq_word : 32'h0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = (state_q == S_RESP) ? rdata_q : 32'h0;
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ladybird_debug_injector.sv
// Self-checking bench: directed cases plus random commands against an
// arithmetic model of the instruction sequences and a scripted core.
module tb_ladybird_debug_injector;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_regno;
  logic [31:0] cmd_addr, cmd_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data;
  logic        inst_done, inst_fault;
  logic [31:0] inst_result;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ladybird_debug_injector dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_regno(cmd_regno), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_done(inst_done), .inst_fault(inst_fault), .inst_result(inst_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encodings from field arithmetic (funct3 = 0 everywhere here).
  function automatic int unsigned hi20(input int unsigned v);
    return (v + 32'h800) / 4096;
  endfunction
  function automatic int unsigned enc_u(input int unsigned rd, input int unsigned imm20);
    return imm20 * 4096 + rd * 128 + 55;
  endfunction
  function automatic int unsigned enc_i(input int unsigned rd, input int unsigned rs1,
                                        input int unsigned imm12, input int unsigned opc);
    return imm12 * 1048576 + rs1 * 32768 + rd * 128 + opc;
  endfunction
  function automatic int unsigned enc_s(input int unsigned rs2, input int unsigned rs1,
                                        input int unsigned imm12);
    return (imm12 / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + (imm12 % 32) * 128 + 35;
  endfunction

  task automatic model(input logic [1:0] op, input int unsigned rn, input int unsigned ad,
                       input int unsigned dt, output logic [31:0] sq[3], output int n);
    sq[0] = 0; sq[1] = 0; sq[2] = 0;
    case (op)
      2'd0: begin n = 1; sq[0] = enc_i(0, rn, 0, 19); end
      2'd1: begin n = 2; sq[0] = enc_u(rn, hi20(dt)); sq[1] = enc_i(rn, rn, dt % 4096, 19); end
      2'd2: begin
        n = 3; sq[0] = enc_u(5, hi20(ad)); sq[1] = enc_i(5, 5, ad % 4096, 3); sq[2] = enc_i(0, 5, 0, 19);
      end
      default: begin
        n = 3; sq[0] = enc_u(5, hi20(ad)); sq[1] = enc_i(6, 0, dt % 256, 19); sq[2] = enc_s(6, 5, ad % 4096);
      end
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] rn, input logic [31:0] ad,
                         input logic [31:0] dt, input int fstep, input logic [31:0] res,
                         input int rdly);
    logic [31:0] sq[3];
    int n, lat;
    bit faulted;
    model(op, rn, ad, dt, sq, n);
    faulted = (fstep >= 0) && (fstep < n);
    cmd_valid = 1; cmd_op = op; cmd_regno = rn; cmd_addr = ad; cmd_data = dt;
    chk("cmd_ready_idle", cmd_ready, 1);
    lat = 0;
    @(negedge clk); lat++; cmd_valid = 0;
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < rdly; d++) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_data", inst_data, sq[k]);
        chk("hold_cmd_ready", cmd_ready, 0);
        chk("hold_busy", busy, 1);
        inst_done = (d == 1); inst_fault = (d == 1);
        @(negedge clk); lat++;
        inst_done = 0; inst_fault = 0;
      end
      chk("issue_valid", inst_valid, 1);
      chk("issue_data", inst_data, sq[k]);
      inst_ready = 1;
      @(negedge clk); lat++; inst_ready = 0;
      chk("wait_novalid", inst_valid, 0);
      chk("wait_noresp", resp_valid, 0);
      inst_done = 1; inst_fault = (k == fstep);
      inst_result = (k == n - 1) ? res : $urandom;
      @(negedge clk); lat++;
      inst_done = 0; inst_fault = 0;
      if (k == fstep) break;
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_err", resp_err, faulted);
    chk("resp_data", resp_data, (!faulted && (op == 2'd0 || op == 2'd2)) ? res : 32'h0);
    chk("resp_novalid_inst", inst_valid, 0);
    if (!faulted && rdly == 0) chk("latency", lat, 2 * n + 1);
    @(negedge clk);
    chk("resp_pulse_end", resp_valid, 0);
    chk("back_idle_ready", cmd_ready, 1);
    chk("back_idle_busy", busy, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [1:0] op;
    int fs;
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_regno = 0; cmd_addr = 0; cmd_data = 0;
    inst_ready = 0; inst_done = 0; inst_fault = 0; inst_result = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    @(negedge clk);

    // Literal encodings for the headline cases, independent of the model.
    begin
      logic [31:0] sq[3];
      int n;
      model(2'd1, 10, 0, 32'h12345FFF, sq, n);
      chk("lit_lui", sq[0], 32'h12346537);
      chk("lit_addi", sq[1], 32'hFFF50513);
      model(2'd2, 0, 32'h80000800, 0, sq, n);
      chk("lit_lb", sq[1], 32'h80028283);
    end

    run_cmd(2'd1, 5'd10, 32'h0, 32'h12345FFF, -1, 32'h0, 0);
    run_cmd(2'd0, 5'd3, 32'h0, 32'h0, -1, 32'hDEADBEEF, 0);
    run_cmd(2'd2, 5'd0, 32'h80000800, 32'h0, -1, 32'hFFFFFF80, 0);
    run_cmd(2'd3, 5'd0, 32'h00001234, 32'h000000A5, 0, 32'h0, 0);
    run_cmd(2'd0, 5'd7, 32'h0, 32'h0, -1, 32'h13572468, 0);
    run_cmd(2'd1, 5'd0, 32'h0, 32'h00000800, -1, 32'h0, 5);
    run_cmd(2'd3, 5'd0, 32'hFFFFFFFF, 32'h0000017F, -1, 32'h0, 0);
    run_cmd(2'd2, 5'd0, 32'hFFFFF800, 32'h0, 1, 32'h0, 0);

    // Reset while waiting on the LB of a memory read.
    cmd_valid = 1; cmd_op = 2'd2; cmd_addr = 32'h00400010;
    @(negedge clk); cmd_valid = 0;
    inst_ready = 1; @(negedge clk); inst_ready = 0;
    inst_done = 1; @(negedge clk); inst_done = 0;
    inst_ready = 1; @(negedge clk); inst_ready = 0;
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_inst_valid", inst_valid, 0);
    chk("mid_rst_inst_data", inst_data, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_data", resp_data, 0);
    chk("mid_rst_resp_err", resp_err, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 0;
    inst_done = 1; inst_result = 32'h55;
    @(negedge clk); inst_done = 0;
    chk("stale_done_resp", resp_valid, 0);
    chk("stale_done_busy", busy, 0);
    run_cmd(2'd0, 5'd31, 32'h0, 32'h0, -1, 32'hCAFEF00D, 0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      b = 8'($urandom);
      fs = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : -1;
      run_cmd(op, 5'($urandom), $urandom, $urandom, fs,
              (op == 2'd2) ? {{24{b[7]}}, b} : $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
